// File: rtl/rand_pkg.sv
// Shared types and constants for the burst randomizer.
//   state_t      : control states of the burst sequencer
//   PAD_BYTE     : fill byte used to complete the last RS block (randomized)
//   TAIL_BYTE    : unrandomized tail byte (only used when RAND_TAIL_EN is defined)
//   LFSR_W       : PRBS register length for 1 + x^14 + x^15
//   seed_to_lfsr : maps the seed port onto the packed LFSR stage vector
package rand_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PAD, TAIL} state_t;

    localparam logic [7:0]  PAD_BYTE  = 8'hFF;
    localparam logic [7:0]  TAIL_BYTE = 8'h00;
    localparam int unsigned LFSR_W    = 15;

    // Packed layout: bit (LFSR_W-k) holds stage r_k, so r1 sits at the MSB and r15 at bit 0.
    // The seed is defined with r1=seed[14] .. r15=seed[0], which lands on the same layout.
    function automatic logic [LFSR_W-1:0] seed_to_lfsr(input logic [LFSR_W-1:0] seed);
        logic [LFSR_W-1:0] st;
        for (int k = 1; k <= LFSR_W; k++) begin
            st[LFSR_W-k] = seed[LFSR_W-k];
        end
        return st;
    endfunction

endpackage

// File: rtl/prbs_byte_step.sv
// Combinational 8-step advance of the 1 + x^14 + x^15 PRBS.
// Ports:
//   state      : current LFSR stages (bit 14 = r1, bit 0 = r15)
//   data       : input byte, MSB processed first
//   data_out   : data XOR PRBS feedback bits
//   state_next : LFSR stages after 8 steps
module prbs_byte_step
    import rand_pkg::*;
(
    input  logic [LFSR_W-1:0] state,
    input  logic [7:0]        data,
    output logic [7:0]        data_out,
    output logic [LFSR_W-1:0] state_next
);

    logic [LFSR_W-1:0] s;
    logic              f;

    always_comb begin
        s        = state;
        f        = 1'b0;
        data_out = '0;
        for (int i = 7; i >= 0; i--) begin
            // f = r14 ^ r15; stages shift toward r15 and f enters at r1
            f           = s[1] ^ s[0];
            data_out[i] = data[i] ^ f;
            s           = {f, s[LFSR_W-1:1]};
        end
        state_next = s;
    end

endmodule

// File: rtl/burst_randomizer.sv
// Byte-serial OFDM burst randomizer feeding an RS encoder. Each burst is whitened with the
// 1 + x^14 + x^15 PRBS reseeded on its first byte, then padded with randomized 0xFF bytes up
// to a whole number of BLK_LEN-byte blocks.
// Build option: define RAND_TAIL_EN to append one unrandomized 0x00 byte carrying out_last;
// otherwise out_last marks the final pad or data byte.
// Ports:
//   clk, reset          : single clock, synchronous active-high reset
//   seed                : per-burst seed, sampled on the first accepted byte
//   in_bits/in_valid    : data byte in; in_last flags the final byte of the burst
//   in_ready            : high in IDLE and DATA only
//   out_bits/out_valid  : registered randomized byte, one cycle after acceptance
//   out_last            : final byte of the burst
module burst_randomizer
    import rand_pkg::*;
#(
    parameter int unsigned w       = 8,
    parameter int unsigned BLK_LEN = 239
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LFSR_W-1:0] seed,
    input  logic [w-1:0]      in_bits,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [w-1:0]      out_bits,
    output logic              out_valid,
    output logic              out_last
);

    localparam logic [7:0] BLK_LEN_B = 8'(BLK_LEN);

    state_t            state;
    logic [LFSR_W-1:0] lfsr;
    logic [7:0]        blk_cnt;

    logic              accept;
    logic [LFSR_W-1:0] step_state;
    logic [LFSR_W-1:0] step_next;
    logic [7:0]        step_data;
    logic [7:0]        rand_byte;
    logic [7:0]        blk_inc;
    logic              blk_full;

    assign in_ready = (state == IDLE) || (state == DATA);
    assign accept   = in_valid && in_ready;

    // First byte of a burst randomizes from the fresh seed, never from the stale LFSR.
    assign step_state = (state == IDLE) ? seed_to_lfsr(seed) : lfsr;
    assign step_data  = (state == PAD) ? PAD_BYTE : in_bits;
    assign blk_inc    = (state == IDLE) ? 8'd1 : blk_cnt + 8'd1;
    assign blk_full   = (blk_inc == BLK_LEN_B);

    prbs_byte_step u_step (
        .state      (step_state),
        .data       (step_data),
        .data_out   (rand_byte),
        .state_next (step_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lfsr      <= '0;
            blk_cnt   <= '0;
            out_bits  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_bits  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            unique case (state)
                IDLE, DATA: begin
                    if (accept) begin
                        out_bits  <= rand_byte;
                        out_valid <= 1'b1;
                        lfsr      <= step_next;
                        blk_cnt   <= blk_full ? 8'd0 : blk_inc;
                        if (!in_last) begin
                            state <= DATA;
                        end else if (!blk_full) begin
                            state <= PAD;
                        end else begin
`ifdef RAND_TAIL_EN
                            state    <= TAIL;
`else
                            state    <= IDLE;
                            out_last <= 1'b1;
`endif
                        end
                    end
                end
                PAD: begin
                    out_bits  <= rand_byte;
                    out_valid <= 1'b1;
                    lfsr      <= step_next;
                    if (blk_full) begin
                        blk_cnt <= 8'd0;
`ifdef RAND_TAIL_EN
                        state    <= TAIL;
`else
                        state    <= IDLE;
                        out_last <= 1'b1;
`endif
                    end else begin
                        blk_cnt <= blk_inc;
                    end
                end
`ifdef RAND_TAIL_EN
                TAIL: begin
                    out_bits  <= TAIL_BYTE;
                    out_valid <= 1'b1;
                    out_last  <= 1'b1;
                    state     <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
